// File: rtl/fp16_normalize_round.sv
// Two-stage normalize + round-to-nearest-even into IEEE-754 binary16.
// Define FP16_NORM_SUBNORM_EN to produce subnormals; otherwise underflow flushes to signed zero.

module leading_one_detector_16 (
  input  logic [15:0] mag_i,
  output logic [3:0]  lz_o
);

  // Highest set bit wins; an all-zero input reports 15.
  always_comb begin
    lz_o = 4'd15;
    for (int i = 0; i < 16; i++) begin
      if (mag_i[i]) lz_o = 4'(15 - i);
    end
  end

endmodule

module fp16_normalize_round #(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [15:0]      in_mag,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_fp16,
  output logic [2:0]       out_flags
);

  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W+1:0] EXP_INF  = (EXP_W+2)'(31);

  logic [3:0]       lz;
  logic [15:0]      normShift;
  logic [EXP_W:0]   s1_exp_d;
  logic             s1Adv, s2Adv;

  logic             s1_valid_q, s1_sign_q, s1_zero_q;
  logic [14:0]      s1_norm_q;
  logic [EXP_W:0]   s1_exp_q;

  logic             s2_valid_q;
  logic [15:0]      s2_fp16_q;
  logic [2:0]       s2_flags_q;

  logic signed [EXP_W+1:0] bexp, bexpRnd;
  logic [9:0]       mant;
  logic             guard, sticky, roundUp;
  logic [10:0]      mantRnd;
  logic [15:0]      fp16_d;
  logic [2:0]       flags_d;

  leading_one_detector_16 u_lod (
    .mag_i (in_mag),
    .lz_o  (lz)
  );

  assign s2Adv     = ~s2_valid_q | out_ready;
  assign s1Adv     = ~s1_valid_q | s2Adv;
  assign in_ready  = s1Adv;
  assign normShift = in_mag << lz;
  assign s1_exp_d  = {in_exp[EXP_W-1], in_exp} - {{(EXP_W-3){1'b0}}, lz};

  // A zero magnitude is the only input whose normalized msb stays clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_norm_q  <= '0;
      s1_exp_q   <= '0;
    end else if (s1Adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= in_sign;
        s1_zero_q <= ~normShift[15];
        s1_norm_q <= normShift[14:0];
        s1_exp_q  <= s1_exp_d;
      end
    end
  end

  assign bexp    = {s1_exp_q[EXP_W], s1_exp_q} + (EXP_W+2)'(15);
  assign mant    = s1_norm_q[14:5];
  assign guard   = s1_norm_q[4];
  assign sticky  = |s1_norm_q[3:0];
  assign roundUp = guard & (sticky | mant[0]);
  assign mantRnd = {1'b0, mant} + {10'd0, roundUp};
  assign bexpRnd = bexp + {{(EXP_W+1){1'b0}}, mantRnd[10]};

`ifdef FP16_NORM_SUBNORM_EN
  logic [EXP_W+1:0] shFull;
  logic [3:0]       sh;
  logic [11:0]      subIn, lostMask;
  logic [10:0]      subShift;
  logic [9:0]       subMant;
  logic             subGuard, subSticky, subUp, subInexact;
  logic [10:0]      subRnd;

  // Denormalize {hidden, mant, guard}; beyond 12 places every bit is sticky.
  assign shFull     = (EXP_W+2)'(1) - bexp;
  assign sh         = (shFull > (EXP_W+2)'(12)) ? 4'd12 : shFull[3:0];
  assign subIn      = {1'b1, mant, guard};
  assign subShift   = 11'(subIn >> sh);
  assign lostMask   = ~(12'hFFF << sh);
  assign subMant    = subShift[10:1];
  assign subGuard   = subShift[0];
  assign subSticky  = sticky | (|(subIn & lostMask));
  assign subUp      = subGuard & (subSticky | subMant[0]);
  assign subRnd     = {1'b0, subMant} + {10'd0, subUp};
  assign subInexact = subGuard | subSticky;
`endif

  always_comb begin
    fp16_d  = {s1_sign_q, 15'h0};
    flags_d = 3'b000;
    if (!s1_zero_q) begin
      if (bexp <= EXP_ZERO) begin
`ifdef FP16_NORM_SUBNORM_EN
        fp16_d  = {s1_sign_q, 4'b0000, subRnd};
        flags_d = {1'b0, ~subRnd[10] & subInexact, subInexact};
`else
        flags_d = 3'b011;
`endif
      end else if (bexpRnd >= EXP_INF) begin
        fp16_d  = {s1_sign_q, 5'h1F, 10'h000};
        flags_d = 3'b101;
      end else begin
        fp16_d  = {s1_sign_q, bexpRnd[4:0], mantRnd[9:0]};
        flags_d = {2'b00, guard | sticky};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_fp16_q  <= 16'h0000;
      s2_flags_q <= 3'b000;
    end else if (s2Adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_fp16_q  <= fp16_d;
        s2_flags_q <= flags_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_fp16  = s2_fp16_q;
  assign out_flags = s2_flags_q;

endmodule

// File: tb/tb_fp16_normalize_round.sv
// Scoreboard bench for fp16_normalize_round; honours FP16_NORM_SUBNORM_EN when defined.

module tb_fp16_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [15:0] in_mag = 16'h0;
  logic [7:0]  in_exp = 8'h0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] out_fp16;
  logic [2:0]  out_flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [18:0] expQ[$];
  int          accQ[$];
  bit          latCheck = 1'b0;
  bit          gapCheck = 1'b0;
  bit          gapArmed = 1'b0;
  bit          doneSend = 1'b0;
  int          lastPop = 0;
  logic [18:0] popExp;
  int          popAcc;
  int          waited;

  fp16_normalize_round #(.EXP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mag    (in_mag),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp16  (out_fp16),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: exact round-to-nearest-even on the integer magnitude.
  function automatic logic [18:0] modelFp(input logic sign, input logic [15:0] mag, input int ex);
    int p, bE, r;
    longint unsigned mf, rem, half;
    bit inexact, up;
    if (mag == 16'h0) return {3'b000, sign, 15'h0};
    p = 0;
    for (int i = 0; i < 16; i++) if (mag[i]) p = i;
    bE = p + ex;
    if (bE <= 0) begin
`ifdef FP16_NORM_SUBNORM_EN
      r = -(ex + 9);
      if (r <= 0) begin
        mf = longint'(mag) << (-r);
        rem = 0;
        half = 1;
      end else if (r >= 40) begin
        mf = 0;
        rem = longint'(mag);
        half = 64'h1 << 39;
      end else begin
        mf = longint'(mag) >> r;
        rem = longint'(mag) & ((64'h1 << r) - 1);
        half = 64'h1 << (r - 1);
      end
      inexact = (rem != 0);
      up = (rem > half) || ((rem == half) && mf[0]);
      mf = mf + longint'(up);
      return {1'b0, (mf < 1024) && inexact, inexact, sign, 15'(mf)};
`else
      return {3'b011, sign, 15'h0};
`endif
    end
    r = p - 10;
    if (r <= 0) begin
      mf = longint'(mag) << (-r);
      rem = 0;
      half = 1;
    end else begin
      mf = longint'(mag) >> r;
      rem = longint'(mag) & ((64'h1 << r) - 1);
      half = 64'h1 << (r - 1);
    end
    inexact = (rem != 0);
    up = (rem > half) || ((rem == half) && mf[0]);
    mf = mf + longint'(up);
    if (mf == 2048) begin
      mf = 1024;
      bE++;
    end
    if (bE >= 31) return {3'b101, sign, 5'h1F, 10'h0};
    return {2'b00, inexact, sign, 5'(bE), 10'(mf & 64'h3FF)};
  endfunction

  task automatic applyStimulus(input logic sign, input logic [15:0] mag, input logic [7:0] ex,
                               input logic [18:0] expected, output int waitCyc);
    waitCyc = 0;
    in_valid = 1'b1;
    in_sign = sign;
    in_mag = mag;
    in_exp = ex;
    @(negedge clk);
    while (!in_ready && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    expQ.push_back(expected);
    accQ.push_back(cyc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendModel(input logic sign, input logic [15:0] mag, input logic [7:0] ex);
    int w;
    applyStimulus(sign, mag, ex, modelFp(sign, mag, int'($signed(ex))), w);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_left", expQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on each handshake, check front of queue while stalled.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", out_valid, 0);
      end else if (out_ready) begin
        popExp = expQ.pop_front();
        popAcc = accQ.pop_front();
        checkOutput("fp16", out_fp16, popExp[15:0]);
        checkOutput("flags", out_flags, popExp[18:16]);
        if (latCheck) checkOutput("latency", cyc - popAcc, 2);
        if (gapCheck && gapArmed) checkOutput("stream_gap", cyc - lastPop, 1);
        gapArmed = gapCheck;
        lastPop = cyc;
      end else begin
        checkOutput("hold_fp16", out_fp16, expQ[0][15:0]);
        checkOutput("hold_flags", out_flags, expQ[0][18:16]);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_fp16", out_fp16, 16'h0000);
    checkOutput("rst_out_flags", out_flags, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    out_ready = 1'b1;
    latCheck = 1'b1;
    applyStimulus(0, 16'h8000, 8'd0,   {3'b000, 16'h3C00}, waited);
    applyStimulus(1, 16'h8000, 8'd0,   {3'b000, 16'hBC00}, waited);
    applyStimulus(0, 16'h8010, 8'd0,   {3'b001, 16'h3C00}, waited);
    applyStimulus(0, 16'h8030, 8'd0,   {3'b001, 16'h3C02}, waited);
    applyStimulus(0, 16'hFFFF, 8'd15,  {3'b101, 16'h7C00}, waited);
    applyStimulus(0, 16'h8000, 8'd20,  {3'b101, 16'h7C00}, waited);
    applyStimulus(0, 16'hFFE0, 8'd15,  {3'b000, 16'h7BFF}, waited);
    applyStimulus(1, 16'h0000, 8'd5,   {3'b000, 16'h8000}, waited);
    applyStimulus(1, 16'h4000, 8'd1,   {3'b000, 16'hBC00}, waited);
    applyStimulus(0, 16'h8000, 8'hF2,  {3'b000, 16'h0400}, waited);
`ifdef FP16_NORM_SUBNORM_EN
    applyStimulus(0, 16'h0001, 8'd0,   {3'b000, 16'h0200}, waited);
    applyStimulus(0, 16'hFFFF, 8'hF1,  {3'b001, 16'h0400}, waited);
    applyStimulus(1, 16'h8000, 8'hF1,  {3'b000, 16'h8200}, waited);
`else
    applyStimulus(0, 16'h0001, 8'd0,   {3'b011, 16'h0000}, waited);
    applyStimulus(0, 16'hFFFF, 8'hF1,  {3'b011, 16'h0000}, waited);
    applyStimulus(1, 16'h8000, 8'hF1,  {3'b011, 16'h8000}, waited);
`endif
    waitDrain();

    $display("[TB] random stream, full speed");
    for (int i = 0; i < 30; i++) begin
      sendModel(1'($urandom_range(0, 1)), 16'($urandom) >> $urandom_range(0, 15),
                8'($urandom_range(0, 60) - 30));
    end
    waitDrain();

    $display("[TB] backpressure");
    latCheck = 1'b0;
    out_ready = 1'b0;
    applyStimulus(0, 16'h8000, 8'd0, {3'b000, 16'h3C00}, waited);
    applyStimulus(0, 16'h8000, 8'd1, {3'b000, 16'h4000}, waited);
    in_valid = 1'b1;
    in_mag = 16'h8000;
    in_exp = 8'd2;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", in_ready, 0);
    end
    gapCheck = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(0, 16'h8000, 8'd2, {3'b000, 16'h4400}, waited);
    checkOutput("bp_in_ready_rise", waited, 0);
    waitDrain();
    gapCheck = 1'b0;
    gapArmed = 1'b0;

    $display("[TB] random stream with random out_ready");
    doneSend = 1'b0;
    fork
      begin
        while (!doneSend) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          sendModel(1'($urandom_range(0, 1)), 16'($urandom) >> $urandom_range(0, 15),
                    8'($urandom_range(0, 60) - 30));
        end
        doneSend = 1'b1;
      end
    join
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] reset mid-flight");
    out_ready = 1'b0;
    applyStimulus(0, 16'h8000, 8'd3, {3'b000, 16'h4800}, waited);
    applyStimulus(0, 16'h8000, 8'd4, {3'b000, 16'h4C00}, waited);
    rst_n = 1'b0;
    expQ.delete();
    accQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    latCheck = 1'b1;
    applyStimulus(0, 16'h8000, 8'hFF, {3'b000, 16'h3800}, waited);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
